mem_access_unit: RTL and testbench

Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register. It turns the registered ALU result and store operand into a data-memory request with byte enables. It holds the pipeline with a stall until the memory answers and returns aligned, sign- or zero-extended load data. Misaligned accesses and bus timeouts are reported as single-cycle flags to the trap logic.

---
 rtl/riscv_mem_pkg.sv | 27 ++
 rtl/load_aligner.sv | 27 ++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the memory-stage load/store unit: load types, store widths
// and the LSU handshake FSM states.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        LtByte  = 3'b000,
        LtHalf  = 3'b001,
        LtWord  = 3'b010,
        LtByteU = 3'b100,
        LtHalfU = 3'b101,
        LtNone  = 3'b111
    } load_type_e;

    typedef enum logic [2:0] {
        SwByte = 3'b000,
        SwHalf = 3'b001,
        SwWord = 3'b010
    } store_width_e;

    localparam logic [2:0] LOAD_NONE = 3'b111;

    typedef enum logic {
        StIdle,
        StWait
    } lsu_state_t;

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_aligner
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (load_type)
            LtByte:  data = {{24{byte_sel[7]}}, byte_sel};
            LtByteU: data = {24'h0, byte_sel};
            LtHalf:  data = {{16{half_sel[15]}}, half_sel};
            LtHalfU: data = {16'h0, half_sel};
            LtWord:  data = rdata;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage LSU: builds the data-memory request, stalls the pipeline until the
// memory answers or times out, and returns extended load data.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_result,
    input  logic [31:0] mem_op2_selected,
    input  logic        mem_memory_write,
    input  logic [2:0]  mem_memory_load_type,
    input  logic [2:0]  mem_func3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        lsu_stall,
    output logic [31:0] lsu_load_data,
    output logic        lsu_misaligned,
    output logic        lsu_bus_error
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    lsu_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        access, misaligned, req, complete, timeout_hit;
    logic [3:0]  be;
    logic [31:0] wdata, aligned_data;

    always_comb begin
        access     = mem_memory_write | (mem_memory_load_type != LOAD_NONE);
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata      = 32'h0;
        if (mem_memory_write) begin
            case (mem_func3)
                SwByte: begin
                    be    = 4'b0001 << mem_result[1:0];
                    wdata = {4{mem_op2_selected[7:0]}};
                end
                SwHalf: begin
                    misaligned = mem_result[0];
                    be         = mem_result[1] ? 4'b1100 : 4'b0011;
                    wdata      = {2{mem_op2_selected[15:0]}};
                end
                SwWord: begin
                    misaligned = |mem_result[1:0];
                    wdata      = mem_op2_selected;
                end
                default: misaligned = 1'b1;
            endcase
        end else begin
            case (mem_memory_load_type)
                LtByte, LtByteU: misaligned = 1'b0;
                LtHalf, LtHalfU: misaligned = mem_result[0];
                LtWord:          misaligned = |mem_result[1:0];
                // Reserved load encodings never reach the bus; LOAD_NONE is masked by access.
                default:         misaligned = 1'b1;
            endcase
        end
        misaligned = misaligned & access;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req         = 1'b0;
        lsu_stall   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access && !misaligned) begin
                    req = 1'b1;
                    if (!dmem_ready) begin
                        lsu_stall = 1'b1;
                        state_d   = StWait;
                        cnt_d     = '0;
                    end
                end
            end
            StWait: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (dmem_ready) begin
                    req     = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    // A ready in this last cycle still completes; only a silent bus errors out.
                    timeout_hit = 1'b1;
                    state_d     = StIdle;
                    cnt_d       = '0;
                end else begin
                    req       = 1'b1;
                    lsu_stall = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    load_aligner u_load_aligner (
        .rdata     (dmem_rdata),
        .addr_lo   (mem_result[1:0]),
        .load_type (mem_memory_load_type),
        .data      (aligned_data)
    );

    assign complete       = req & dmem_ready;
    assign dmem_req       = req;
    assign dmem_we        = req & mem_memory_write;
    assign dmem_addr      = req ? {mem_result[31:2], 2'b00} : 32'h0;
    assign dmem_be        = req ? be : 4'h0;
    assign dmem_wdata     = req ? wdata : 32'h0;
    assign lsu_load_data  = (complete && !mem_memory_write) ? aligned_data : 32'h0;
    assign lsu_misaligned = misaligned;
    assign lsu_bus_error  = timeout_hit;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a driver holds each instruction like a frozen EX/MEM
// register while a monitor scores every completion, misalign flag and bus error.
module tb_mem_access_unit;
    import riscv_mem_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] mem_result;
    logic [31:0] mem_op2_selected;
    logic        mem_memory_write;
    logic [2:0]  mem_memory_load_type;
    logic [2:0]  mem_func3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        lsu_stall;
    logic [31:0] lsu_load_data;
    logic        lsu_misaligned;
    logic        lsu_bus_error;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        int          kind;  // 0 complete, 1 misaligned, 2 bus error
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] ldata;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];

    mem_access_unit #(
        .TIMEOUT (TO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_result           (mem_result),
        .mem_op2_selected     (mem_op2_selected),
        .mem_memory_write     (mem_memory_write),
        .mem_memory_load_type (mem_memory_load_type),
        .mem_func3            (mem_func3),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_be              (dmem_be),
        .dmem_wdata           (dmem_wdata),
        .dmem_ready           (dmem_ready),
        .dmem_rdata           (dmem_rdata),
        .lsu_stall            (lsu_stall),
        .lsu_load_data        (lsu_load_data),
        .lsu_misaligned       (lsu_misaligned),
        .lsu_bus_error        (lsu_bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(input string n, input int k, input logic [31:0] a,
                                input logic [3:0] b, input logic w, input logic [31:0] wd,
                                input logic [31:0] ld, input int s);
        exp_t e;
        e.name = n; e.kind = k; e.addr = a; e.be = b; e.we = w;
        e.wdata = wd; e.ldata = ld; e.stalls = s;
        return e;
    endfunction

    // Called at posedge+1; holds the instruction for 'hold' cycles, ready only at rdy_at.
    task automatic issue(input logic wr, input logic [2:0] lt, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] op2,
                         input logic [31:0] rdata, input int hold, input int rdy_at);
        mem_memory_write     = wr;
        mem_memory_load_type = lt;
        mem_func3            = f3;
        mem_result           = addr;
        mem_op2_selected     = op2;
        dmem_rdata           = rdata;
        for (int c = 0; c < hold; c++) begin
            dmem_ready = (c == rdy_at);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        issue(1'b0, LOAD_NONE, 3'b000, 32'h0, 32'h0, 32'h0, n, -1);
    endtask

    // Monitor: scores each DUT event against the head of the expectation queue.
    initial begin
        int   stall_seen;
        int   kind_act;
        exp_t e;
        stall_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_seen = 0;
            end else if ((dmem_req && dmem_ready) || lsu_misaligned || lsu_bus_error) begin
                kind_act = lsu_bus_error ? 2 : (lsu_misaligned ? 1 : 0);
                if (exp_q.size() == 0) begin
                    chk("pending_expectations", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, ".kind"}, kind_act, e.kind);
                    chk({e.name, ".stall_cycles"}, stall_seen, e.stalls);
                    chk({e.name, ".stall_now"}, lsu_stall, 0);
                    chk({e.name, ".load_data"}, lsu_load_data, e.ldata);
                    chk({e.name, ".req"}, dmem_req, (e.kind == 0) ? 1 : 0);
                    if (e.kind == 0) begin
                        chk({e.name, ".addr"}, dmem_addr, e.addr);
                        chk({e.name, ".be"}, dmem_be, e.be);
                        chk({e.name, ".we"}, dmem_we, e.we);
                        chk({e.name, ".wdata"}, dmem_wdata, e.wdata);
                    end
                end
                stall_seen = 0;
            end else if (lsu_stall) begin
                stall_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                  = 1'b1;
        mem_result           = 32'h0;
        mem_op2_selected     = 32'h0;
        mem_memory_write     = 1'b0;
        mem_memory_load_type = LOAD_NONE;
        mem_func3            = 3'b000;
        dmem_ready           = 1'b0;
        dmem_rdata           = 32'h0;
        #12;
        chk("reset.req", dmem_req, 0);
        chk("reset.we", dmem_we, 0);
        chk("reset.addr", dmem_addr, 0);
        chk("reset.be", dmem_be, 0);
        chk("reset.wdata", dmem_wdata, 0);
        chk("reset.stall", lsu_stall, 0);
        chk("reset.load_data", lsu_load_data, 0);
        chk("reset.misaligned", lsu_misaligned, 0);
        chk("reset.bus_error", lsu_bus_error, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        exp_q.push_back(mk("lw_100", 0, 32'h100, 4'hF, 0, 32'h0, 32'hDEADBEEF, 0));
        issue(1'b0, LtWord, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0);
        exp_q.push_back(mk("lb_103", 0, 32'h100, 4'hF, 0, 32'h0, 32'hFFFFFF80, 3));
        issue(1'b0, LtByte, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 4, 3);
        exp_q.push_back(mk("lbu_103", 0, 32'h100, 4'hF, 0, 32'h0, 32'h00000080, 3));
        issue(1'b0, LtByteU, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 4, 3);
        exp_q.push_back(mk("sh_202", 0, 32'h200, 4'b1100, 1, 32'hABCDABCD, 32'h0, 0));
        issue(1'b1, LOAD_NONE, SwHalf, 32'h202, 32'h1234ABCD, 32'h0, 1, 0);
        idle(1);
        // Ready offered while misaligned must be ignored.
        exp_q.push_back(mk("lw_101_mis", 1, 32'h0, 4'h0, 0, 32'h0, 32'h0, 0));
        issue(1'b0, LtWord, 3'b000, 32'h101, 32'h0, 32'hFFFFFFFF, 1, 0);
        exp_q.push_back(mk("sh_003_mis", 1, 32'h0, 4'h0, 0, 32'h0, 32'h0, 0));
        issue(1'b1, LOAD_NONE, SwHalf, 32'h003, 32'h55AA55AA, 32'h0, 1, -1);
        exp_q.push_back(mk("lh_102", 0, 32'h100, 4'hF, 0, 32'h0, 32'hFFFF8001, 1));
        issue(1'b0, LtHalf, 3'b000, 32'h102, 32'h0, 32'h80011234, 2, 1);
        exp_q.push_back(mk("lhu_100", 0, 32'h100, 4'hF, 0, 32'h0, 32'h0000F00D, 0));
        issue(1'b0, LtHalfU, 3'b000, 32'h100, 32'h0, 32'h8001F00D, 1, 0);
        exp_q.push_back(mk("sb_401", 0, 32'h400, 4'b0010, 1, 32'hA5A5A5A5, 32'h0, 2));
        issue(1'b1, LOAD_NONE, SwByte, 32'h401, 32'h123456A5, 32'h0, 3, 2);
        // Load type is ignored on a store.
        exp_q.push_back(mk("sw_404", 0, 32'h404, 4'hF, 1, 32'hCAFEF00D, 32'h0, 0));
        issue(1'b1, LtHalf, SwWord, 32'h404, 32'hCAFEF00D, 32'h0, 1, 0);
        exp_q.push_back(mk("st_f3_011_mis", 1, 32'h0, 4'h0, 0, 32'h0, 32'h0, 0));
        issue(1'b1, LOAD_NONE, 3'b011, 32'h000, 32'h11111111, 32'h0, 1, -1);
        exp_q.push_back(mk("lb_000", 0, 32'h000, 4'hF, 0, 32'h0, 32'h0000007F, 0));
        issue(1'b0, LtByte, 3'b000, 32'h000, 32'h0, 32'h0000007F, 1, 0);
        exp_q.push_back(mk("lw_500_timeout", 2, 32'h0, 4'h0, 0, 32'h0, 32'h0, TO));
        issue(1'b0, LtWord, 3'b000, 32'h500, 32'h0, 32'h0, TO + 1, -1);
        mem_memory_load_type = LOAD_NONE;
        #1;
        chk("after_timeout.req", dmem_req, 0);
        chk("after_timeout.stall", lsu_stall, 0);
        @(posedge clk);
        #1;
        exp_q.push_back(mk("lw_504_ready_wins", 0, 32'h504, 4'hF, 0, 32'h0, 32'h12345678, TO));
        issue(1'b0, LtWord, 3'b000, 32'h504, 32'h0, 32'h12345678, TO + 1, TO);
        idle(1);

        // Reset in the second WAIT cycle; the upstream register resets alongside.
        mem_memory_write     = 1'b0;
        mem_memory_load_type = LtWord;
        mem_result           = 32'h700;
        dmem_ready           = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_wait.pre_req", dmem_req, 1);
        chk("rst_wait.pre_stall", lsu_stall, 1);
        #2;
        rst                  = 1'b1;
        mem_memory_load_type = LOAD_NONE;
        mem_result           = 32'h0;
        #1;
        chk("rst_wait.req", dmem_req, 0);
        chk("rst_wait.stall", lsu_stall, 0);
        chk("rst_wait.bus_error", lsu_bus_error, 0);
        chk("rst_wait.load_data", lsu_load_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        exp_q.push_back(mk("post_rst_lw_600", 0, 32'h600, 4'hF, 0, 32'h0, 32'h0BADF00D, 0));
        issue(1'b0, LtWord, 3'b000, 32'h600, 32'h0, 32'h0BADF00D, 1, 0);
        exp_q.push_back(mk("post_rst_lhu_606", 0, 32'h604, 4'hF, 0, 32'h0, 32'h0000BEEF, 2));
        issue(1'b0, LtHalfU, 3'b000, 32'h606, 32'h0, 32'hBEEF0000, 3, 2);
        exp_q.push_back(mk("post_rst_timeout", 2, 32'h0, 4'h0, 0, 32'h0, 32'h0, TO));
        issue(1'b0, LtByte, 3'b000, 32'h608, 32'h0, 32'h0, TO + 1, -1);
        idle(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
